// File: rtl/spatz_vrf_wr_arbiter_pkg.sv
// ============================================================================
// Module   : spatz_vrf_wr_arbiter_pkg
// Brief    : VRF geometry, write-port types and requester indices.
// Revision : 1.0
// ============================================================================
`default_nettype none

package spatz_vrf_wr_arbiter_pkg;

    localparam int NR_VRF_BANKS = 4;
    localparam int NR_ROWS      = 32;
    localparam int VREG_DATA_W  = 32;
    localparam int BANK_W       = $clog2(NR_VRF_BANKS);
    localparam int ROW_W        = $clog2(NR_ROWS);

    typedef logic [BANK_W-1:0] vrf_bank_t;
    // Bank-local row: the full vreg address minus the bank-select bits.
    typedef logic [ROW_W-1:0]  vregfile_addr_t;

    typedef struct packed {
        vrf_bank_t      bank;
        vregfile_addr_t vreg;
    } vreg_addr_t;

    typedef logic [VREG_DATA_W-1:0]   vreg_data_t;
    typedef logic [VREG_DATA_W/8-1:0] vreg_be_t;

    localparam int VFU_VD_WD   = 0;
    localparam int VLSU_VD_WD  = 1;
    localparam int VSLDU_VD_WD = 2;

endpackage

`default_nettype wire

// File: rtl/spatz_vrf_wr_arbiter_if.sv
// ============================================================================
// Module   : spatz_vrf_wr_arbiter_if
// Brief    : Requester write ports and per-bank vregfile write ports.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface spatz_vrf_wr_arbiter_if #(
    parameter int NR_REQ = 3
);
    import spatz_vrf_wr_arbiter_pkg::*;

    vreg_addr_t     [NR_REQ-1:0]       req_waddr_i;
    vreg_data_t     [NR_REQ-1:0]       req_wdata_i;
    vreg_be_t       [NR_REQ-1:0]       req_wbe_i;
    logic           [NR_REQ-1:0]       req_we_i;
    logic           [NR_REQ-1:0]       req_wvalid_o;
    vregfile_addr_t [NR_VRF_BANKS-1:0] bank_waddr_o;
    vreg_data_t     [NR_VRF_BANKS-1:0] bank_wdata_o;
    vreg_be_t       [NR_VRF_BANKS-1:0] bank_wbe_o;
    logic           [NR_VRF_BANKS-1:0] bank_we_o;

    modport master (
        output req_waddr_i, req_wdata_i, req_wbe_i, req_we_i,
        input  req_wvalid_o, bank_waddr_o, bank_wdata_o, bank_wbe_o, bank_we_o
    );

    modport slave (
        input  req_waddr_i, req_wdata_i, req_wbe_i, req_we_i,
        output req_wvalid_o, bank_waddr_o, bank_wdata_o, bank_wbe_o, bank_we_o
    );

endinterface

`default_nettype wire

// File: rtl/spatz_vrf_wr_arbiter_age_cnt.sv
// ============================================================================
// Module   : spatz_vrf_age_cnt
// Brief    : Saturating count of consecutive denied cycles for one requester.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spatz_vrf_age_cnt #(
    parameter int STARV_LIMIT = 4
) (
    input  wire logic clk_i,
    input  wire logic rst_ni,
    input  wire logic req_i,
    input  wire logic gnt_i,
    output logic      urgent_o
);

    localparam int                c_age_w = $clog2(STARV_LIMIT + 1);
    localparam logic [c_age_w-1:0] c_limit = c_age_w'(STARV_LIMIT);

    logic [c_age_w-1:0] r_age;

    // A grant or a withdrawn request both restart the count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_age <= '0;
        end else if (req_i && !gnt_i) begin
            if (r_age != c_limit) begin
                r_age <= r_age + c_age_w'(1);
            end
        end else begin
            r_age <= '0;
        end
    end

    assign urgent_o = (r_age == c_limit);

endmodule

`default_nettype wire

// File: rtl/spatz_vrf_wr_arbiter.sv
// ============================================================================
// Module   : spatz_vrf_wr_arbiter
// Brief    : Per-bank VRF write arbiter, fixed priority plus age-based urgency.
//            Define SPATZ_VRF_WR_AGING_EN to enable the age counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spatz_vrf_wr_arbiter
    import spatz_vrf_wr_arbiter_pkg::*;
#(
    parameter int NR_REQ      = 3,
    parameter int STARV_LIMIT = 4,
    parameter int CNT_WIDTH   = 32
) (
    input  wire logic                 clk_i,
    input  wire logic                 rst_ni,
    spatz_vrf_wr_arbiter_if.slave     bus,
    output logic [NR_REQ-1:0]         urgent_o,
    output logic [CNT_WIDTH-1:0]      conflict_cnt_o
);

    if (STARV_LIMIT < 1) begin : g_starv_limit_check
        $error("STARV_LIMIT must be at least 1");
    end

    logic [NR_REQ-1:0]    w_urgent;
    logic [NR_REQ-1:0]    w_wvalid;
    logic [NR_REQ-1:0]    w_denied;
    logic [NR_REQ-1:0]    w_bank_gnt [NR_VRF_BANKS];
    logic [CNT_WIDTH-1:0] r_conflict_cnt;

    for (genvar b = 0; b < NR_VRF_BANKS; b++) begin : g_bank
        logic [NR_REQ-1:0] w_cand;
        logic [NR_REQ-1:0] w_sel;

        for (genvar i = 0; i < NR_REQ; i++) begin : g_cand
            assign w_cand[i] = bus.req_we_i[i] &&
                               (bus.req_waddr_i[i].bank == vrf_bank_t'(b));
        end

        // Urgent candidates shadow the rest; lowest index wins within the chosen set.
        assign w_sel         = (|(w_cand & w_urgent)) ? (w_cand & w_urgent) : w_cand;
        assign w_bank_gnt[b] = w_sel & (~w_sel + NR_REQ'(1));
    end

    always_comb begin
        w_wvalid         = '0;
        bus.bank_we_o    = '0;
        bus.bank_waddr_o = '0;
        bus.bank_wdata_o = '0;
        bus.bank_wbe_o   = '0;
        for (int b = 0; b < NR_VRF_BANKS; b++) begin
            w_wvalid = w_wvalid | w_bank_gnt[b];
            for (int i = 0; i < NR_REQ; i++) begin
                if (w_bank_gnt[b][i]) begin
                    bus.bank_we_o[b]    = 1'b1;
                    bus.bank_waddr_o[b] = bus.req_waddr_i[i].vreg;
                    bus.bank_wdata_o[b] = bus.req_wdata_i[i];
                    bus.bank_wbe_o[b]   = bus.req_wbe_i[i];
                end
            end
        end
    end

    assign bus.req_wvalid_o = w_wvalid;
    assign w_denied         = bus.req_we_i & ~w_wvalid;

`ifdef SPATZ_VRF_WR_AGING_EN
    for (genvar i = 0; i < NR_REQ; i++) begin : g_age
        spatz_vrf_age_cnt #(
            .STARV_LIMIT (STARV_LIMIT)
        ) u_age_cnt (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .req_i    (bus.req_we_i[i]),
            .gnt_i    (w_wvalid[i]),
            .urgent_o (w_urgent[i])
        );
    end
`else
    assign w_urgent = '0;
`endif

    assign urgent_o = w_urgent;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_conflict_cnt <= '0;
        end else if (|w_denied) begin
            r_conflict_cnt <= r_conflict_cnt + CNT_WIDTH'(1);
        end
    end

    assign conflict_cnt_o = r_conflict_cnt;

endmodule

`default_nettype wire

// File: tb/tb_spatz_vrf_wr_arbiter.sv
// ============================================================================
// Module   : tb_spatz_vrf_wr_arbiter
// Brief    : Directed and random checks of the VRF write arbiter against a
//            requester-level reference model (aging follows SPATZ_VRF_WR_AGING_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spatz_vrf_wr_arbiter;
    import spatz_vrf_wr_arbiter_pkg::*;

    localparam int NR_REQ      = 3;
    localparam int STARV_LIMIT = 4;
    localparam int CNT_WIDTH   = 4;
`ifdef SPATZ_VRF_WR_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_ni;
    logic [NR_REQ-1:0]    urgent;
    logic [CNT_WIDTH-1:0] conflict_cnt;

    always #5 clk = ~clk;

    spatz_vrf_wr_arbiter_if #(.NR_REQ(NR_REQ)) bus ();

    spatz_vrf_wr_arbiter #(
        .NR_REQ      (NR_REQ),
        .STARV_LIMIT (STARV_LIMIT),
        .CNT_WIDTH   (CNT_WIDTH)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .bus            (bus),
        .urgent_o       (urgent),
        .conflict_cnt_o (conflict_cnt)
    );

    // Requester-side state
    bit         rq_we   [NR_REQ];
    int         rq_bank [NR_REQ];
    int         rq_vreg [NR_REQ];
    vreg_data_t rq_data [NR_REQ];
    vreg_be_t   rq_be   [NR_REQ];

    // Reference model state
    int                m_age [NR_REQ];
    int                m_cnt;
    int                e_win [NR_VRF_BANKS];
    logic [NR_REQ-1:0] e_gnt;
    vreg_data_t        m_mem [NR_VRF_BANKS][NR_ROWS];
    vreg_data_t        d_mem [NR_VRF_BANKS][NR_ROWS];

    logic [NR_REQ-1:0] last_wvalid;
    logic [NR_REQ-1:0] last_urgent;
    vreg_data_t        last_wdata [NR_VRF_BANKS];

    int n_cmp;
    int n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic vreg_data_t merge(input vreg_data_t old, input vreg_data_t d,
                                         input vreg_be_t be);
        vreg_data_t r;
        r = old;
        for (int k = 0; k < VREG_DATA_W / 8; k++) begin
            if (be[k]) r[8*k +: 8] = d[8*k +: 8];
        end
        return r;
    endfunction

    task automatic set_req(input int i, input int bank, input int vreg);
        rq_we[i]   = 1'b1;
        rq_bank[i] = bank;
        rq_vreg[i] = vreg;
        rq_data[i] = vreg_data_t'($urandom);
        rq_be[i]   = vreg_be_t'($urandom_range(1, 15));
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NR_REQ; i++) rq_we[i] = 1'b0;
    endtask

    task automatic apply();
        for (int i = 0; i < NR_REQ; i++) begin
            bus.req_we_i[i]    = rq_we[i];
            bus.req_waddr_i[i] = {vrf_bank_t'(rq_bank[i]), vregfile_addr_t'(rq_vreg[i])};
            bus.req_wdata_i[i] = rq_data[i];
            bus.req_wbe_i[i]   = rq_be[i];
        end
    endtask

    // Winner per bank: lowest-index urgent candidate, else lowest-index candidate.
    task automatic model_eval();
        for (int b = 0; b < NR_VRF_BANKS; b++) e_win[b] = -1;
        if (AGING) begin
            for (int i = 0; i < NR_REQ; i++)
                if (rq_we[i] && m_age[i] == STARV_LIMIT && e_win[rq_bank[i]] < 0)
                    e_win[rq_bank[i]] = i;
        end
        for (int i = 0; i < NR_REQ; i++)
            if (rq_we[i] && e_win[rq_bank[i]] < 0) e_win[rq_bank[i]] = i;
        for (int i = 0; i < NR_REQ; i++)
            e_gnt[i] = rq_we[i] && (e_win[rq_bank[i]] == i);
    endtask

    task automatic model_clock();
        bit any_denied;
        any_denied = 1'b0;
        for (int i = 0; i < NR_REQ; i++) begin
            if (rq_we[i] && !e_gnt[i]) begin
                any_denied = 1'b1;
                m_age[i]   = (m_age[i] + 1 > STARV_LIMIT) ? STARV_LIMIT : m_age[i] + 1;
            end else begin
                m_age[i] = 0;
            end
        end
        for (int b = 0; b < NR_VRF_BANKS; b++) begin
            if (e_win[b] >= 0)
                m_mem[b][rq_vreg[e_win[b]]] = merge(m_mem[b][rq_vreg[e_win[b]]],
                                                    rq_data[e_win[b]], rq_be[e_win[b]]);
        end
        if (any_denied) m_cnt = (m_cnt + 1) % (1 << CNT_WIDTH);
    endtask

    task automatic check_cycle(input string tag);
        logic [NR_REQ-1:0] e_urg;
        logic [41:0]       e_bank;
        int                w;
        for (int i = 0; i < NR_REQ; i++) e_urg[i] = AGING && (m_age[i] == STARV_LIMIT);
        chk({tag, ".wvalid"}, 64'(bus.req_wvalid_o), 64'(e_gnt));
        chk({tag, ".urgent"}, 64'(urgent), 64'(e_urg));
        chk({tag, ".cnt"}, 64'(conflict_cnt), 64'(m_cnt));
        for (int b = 0; b < NR_VRF_BANKS; b++) begin
            e_bank = '0;
            if (e_win[b] >= 0) begin
                w      = e_win[b];
                e_bank = {1'b1, vregfile_addr_t'(rq_vreg[w]), rq_data[w], rq_be[w]};
            end
            chk($sformatf("%s.bank%0d", tag, b),
                64'({bus.bank_we_o[b], bus.bank_waddr_o[b], bus.bank_wdata_o[b], bus.bank_wbe_o[b]}),
                64'(e_bank));
        end
    endtask

    // Entered just after a rising edge; returns 1 time unit after the next one.
    task automatic cycle(input string tag);
        apply();
        @(negedge clk);
        model_eval();
        check_cycle(tag);
        last_wvalid = bus.req_wvalid_o;
        last_urgent = urgent;
        for (int b = 0; b < NR_VRF_BANKS; b++) begin
            last_wdata[b] = bus.bank_wdata_o[b];
            if (bus.bank_we_o[b])
                d_mem[b][bus.bank_waddr_o[b]] = merge(d_mem[b][bus.bank_waddr_o[b]],
                                                      bus.bank_wdata_o[b], bus.bank_wbe_o[b]);
        end
        @(posedge clk);
        model_clock();
        #1;
        for (int i = 0; i < NR_REQ; i++) if (e_gnt[i]) rq_we[i] = 1'b0;
    endtask

    // Pulse reset between clock edges; registered outputs must clear without a clock.
    task automatic async_reset(input string tag);
        rst_ni = 1'b0;
        #1;
        chk({tag, ".cnt"}, 64'(conflict_cnt), 64'(0));
        chk({tag, ".urgent"}, 64'(urgent), 64'(0));
        for (int i = 0; i < NR_REQ; i++) m_age[i] = 0;
        m_cnt = 0;
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_ni = 1'b0;
        m_cnt  = 0;
        for (int i = 0; i < NR_REQ; i++) begin
            rq_we[i] = 1'b0; rq_bank[i] = 0; rq_vreg[i] = 0;
            rq_data[i] = '0; rq_be[i] = '0; m_age[i] = 0;
        end
        for (int b = 0; b < NR_VRF_BANKS; b++)
            for (int r = 0; r < NR_ROWS; r++) begin
                m_mem[b][r] = '0;
                d_mem[b][r] = '0;
            end
        apply();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.cnt", 64'(conflict_cnt), 64'(0));
        chk("reset.urgent", 64'(urgent), 64'(0));
        chk("reset.wvalid", 64'(bus.req_wvalid_o), 64'(0));
        chk("reset.bank_we", 64'(bus.bank_we_o), 64'(0));
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // Disjoint banks: everyone granted at once
        set_req(VFU_VD_WD, 0, 3);
        set_req(VLSU_VD_WD, 1, 4);
        set_req(VSLDU_VD_WD, 2, 5);
        cycle("t1");
        chk("t1.grant", 64'(last_wvalid), 64'(3'b111));
        cycle("t1.idle");
        chk("t1.cnt", 64'(conflict_cnt), 64'(0));

        // Fixed priority on a shared bank
        set_req(0, 1, 6); rq_data[0] = 32'hAAAA_0001;
        set_req(1, 1, 6); rq_data[1] = 32'hBBBB_0002;
        cycle("t2");
        chk("t2.grant", 64'(last_wvalid), 64'(3'b001));
        chk("t2.bank1_data", 64'(last_wdata[1]), 64'(32'hAAAA_0001));
        chk("t2.cnt", 64'(conflict_cnt), 64'(1));
        clear_reqs();
        cycle("t2.idle");

        // Starvation: req0 streams into bank0 while req2 waits there
        async_reset("t3.rst");
        set_req(2, 0, 7);
        for (int k = 1; k <= 8; k++) begin
            if (!rq_we[0]) set_req(0, 0, k);
            cycle("t3");
            chk("t3.req2_gnt", 64'(last_wvalid[2]), 64'(AGING && k == 5));
            chk("t3.req0_gnt", 64'(last_wvalid[0]), 64'(!(AGING && k == 5)));
            if (k == 5) chk("t3.urgent2", 64'(last_urgent[2]), 64'(AGING));
            if (k == 6) chk("t3.age_clear", 64'(last_urgent[2]), 64'(0));
        end
        clear_reqs();
        cycle("t3.idle");

        // Async reset with age[2] at 3; aging must restart from zero
        async_reset("t5.rst0");
        set_req(2, 1, 9);
        for (int k = 1; k <= 3; k++) begin
            if (!rq_we[0]) set_req(0, 1, k);
            cycle("t5.pre");
        end
        async_reset("t5.rst");
        for (int k = 1; k <= 5; k++) begin
            if (!rq_we[0]) set_req(0, 1, k + 10);
            cycle("t5.post");
            chk("t5.req2_gnt", 64'(last_wvalid[2]), 64'(AGING && k == 5));
            chk("t5.urgent2", 64'(last_urgent[2]), 64'(AGING && k == 5));
        end
        clear_reqs();
        cycle("t5.idle");

        // Counter wrap: 16 conflicting cycles on a 4-bit counter
        async_reset("t6.rst");
        for (int k = 1; k <= 16; k++) begin
            if (!rq_we[0]) set_req(0, 3, k);
            if (!rq_we[1]) set_req(1, 3, k + 16);
            cycle("t6");
            if (k == 15) chk("t6.cnt15", 64'(conflict_cnt), 64'(15));
        end
        chk("t6.wrap", 64'(conflict_cnt), 64'(0));
        clear_reqs();
        cycle("t6.idle");

        // Random traffic, biased toward banks 0/1 to provoke conflicts
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR_REQ; i++) begin
                if (!rq_we[i]) begin
                    if ($urandom_range(0, 3) != 0)
                        set_req(i, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 1))
                                                               : int'($urandom_range(0, 3)),
                                int'($urandom_range(0, NR_ROWS - 1)));
                end else if ($urandom_range(0, 39) == 0) begin
                    rq_we[i] = 1'b0;
                end
            end
            cycle("rnd");
        end
        clear_reqs();
        cycle("rnd.idle");

        for (int b = 0; b < NR_VRF_BANKS; b++)
            for (int r = 0; r < NR_ROWS; r++)
                chk($sformatf("mem.b%0d.r%0d", b, r), 64'(d_mem[b][r]), 64'(m_mem[b][r]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
